// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_gen
// Purpose  : Upstream command stage for the set/reset flip-flop. Turns two
//            raw asynchronous, possibly bouncy request lines into clean
//            single-cycle s/r pulses. Each line is synchronised, debounced
//            and rising-edge detected. The two events are then arbitrated so
//            that s and r are never high together. A hold-off window after
//            every pulse discards new requests.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronised cycles (>=1) needed before the
//                     debounced level changes
//   HOLDOFF_CYCLES  : cycles (>=0) after a pulse during which requests are
//                     dropped
//
// Ports:
//   clk      in   single clock, rising-edge active
//   reset    in   synchronous, active-high reset
//   set_in   in   raw asynchronous set request (level, active-high)
//   clr_in   in   raw asynchronous clear request (level, active-high)
//   s        out  one-cycle set pulse
//   r        out  one-cycle reset pulse
//   busy     out  high while a pulse or its hold-off window is in progress
//   conflict out  one-cycle pulse when set and clear events coincide in idle
//   dropped  out  one-cycle pulse when an event is discarded while busy
//
// Build option:
//   SR_CMD_CLR_PRIORITY_EN : when defined, coincident set/clear events in
//                            idle issue an r pulse (clear wins) and still
//                            flag conflict. When undefined, no pulse is
//                            issued.
//
// Revision : 1.0  initial release
// ============================================================================
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic dropped
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  // The hold-off counter keeps one bit even when hold-off is disabled,
  // which avoids a zero-width vector.
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Channel 0 is the set request and channel 1 is the clear request.
  logic [1:0] raw;
  logic [1:0] evt;

  assign raw = {clr_in, set_in};

  // --------------------------------------------------------------------------
  // Per-channel synchroniser, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < 2; g++) begin : g_chan
      logic [1:0]    sync;
      logic          level;
      logic          level_d;
      logic [DW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync    <= '0;
          level   <= 1'b0;
          level_d <= 1'b0;
          cnt     <= '0;
        end else begin
          sync    <= {sync[0], raw[g]};
          level_d <= level;
          // The counter tracks how many consecutive cycles the synchronised
          // input has disagreed with the debounced level. The level flips on
          // the DEBOUNCE_CYCLES-th disagreeing cycle.
          if (sync[1] == level) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            level <= ~level;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
      end

      assign evt[g] = level & ~level_d;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration FSM
  // --------------------------------------------------------------------------
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_nxt;
  logic          s_nxt;
  logic          r_nxt;
  logic          conflict_nxt;
  logic          dropped_nxt;

  // State register. The pulse and flag outputs are registered here so that
  // they appear in the cycle after the event cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      s        <= s_nxt;
      r        <= r_nxt;
      conflict <= conflict_nxt;
      dropped  <= dropped_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (evt == 2'b01 || evt == 2'b10) begin
          state_nxt = ST_PULSE;
        end else if (evt == 2'b11) begin
`ifdef SR_CMD_CLR_PRIORITY_EN
          state_nxt = ST_PULSE;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_PULSE: begin
        if (HOLDOFF_CYCLES > 0) begin
          state_nxt    = ST_HOLD;
          hold_cnt_nxt = HOLD_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // The counter is loaded with HOLDOFF_CYCLES-1, so reaching zero marks
        // the final hold-off cycle.
        if (hold_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt - HW'(1);
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic. This block computes the values that are registered on the
  // next edge.
  always_comb begin
    s_nxt        = 1'b0;
    r_nxt        = 1'b0;
    conflict_nxt = 1'b0;
    dropped_nxt  = 1'b0;
    if (state == ST_IDLE) begin
      s_nxt        = (evt == 2'b01);
      conflict_nxt = (evt == 2'b11);
`ifdef SR_CMD_CLR_PRIORITY_EN
      r_nxt        = (evt == 2'b10) || (evt == 2'b11);
`else
      r_nxt        = (evt == 2'b10);
`endif
    end else begin
      // Events that arrive while busy are discarded, never queued.
      dropped_nxt = |evt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_cmd_gen
// Purpose  : Scoreboard bench for sr_cmd_gen.
//            - A behavioural model runs on every rising edge and pushes the
//              expected {s,r,busy,conflict,dropped} for the following cycle
//              into a queue.
//            - A separate monitor pops each entry 1 ns after the edge and
//              compares it with the DUT outputs.
//            - Outputs are checked to be zero during every reset cycle.
//            - Bounded waits check that expected pulses arrive in time.
//            - Stimulus covers the following, then randomised request
//              patterns:
//                - reset
//                - latency
//                - debounce
//                - hold-off drop
//                - conflict
//                - mid-operation reset
// Revision : 1.1  added reset-state and bounded-wait checks
// ============================================================================
module tb_sr_cmd_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic set_in = 1'b0;
    logic clr_in = 1'b0;
    logic s;
    logic r;
    logic busy;
    logic conflict;
    logic dropped;

    always #5 clk = ~clk;

    sr_cmd_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .set_in   (set_in),
        .clr_in   (clr_in),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .conflict (conflict),
        .dropped  (dropped)
    );

    int         checks = 0;
    int         passes = 0;
    int         cycle  = 0;
    logic [4:0] exp_q[$];

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    bit         m_sy0[2];
    bit         m_sy1[2];
    bit         m_lvl[2];
    bit         m_prv[2];
    bit [1:0]   m_hist[$];
    int         m_rem = 0;
    bit [1:0]   m_ev;
    bit         m_diff;
    bit         e_s;
    bit         e_r;
    bit         e_cf;
    bit         e_dr;

    always @(posedge clk) begin
        cycle++;
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_sy0[ch] = 1'b0;
                m_sy1[ch] = 1'b0;
                m_lvl[ch] = 1'b0;
                m_prv[ch] = 1'b0;
            end
            m_hist.delete();
            m_rem = 0;
            exp_q.push_back(5'b00000);
        end else begin
            m_hist.push_back({m_sy1[1], m_sy1[0]});
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            for (int ch = 0; ch < 2; ch++) begin
                m_ev[ch]  = m_lvl[ch] && !m_prv[ch];
                m_prv[ch] = m_lvl[ch];
                m_diff    = (m_hist.size() >= DEB);
                foreach (m_hist[k]) if (m_hist[k][ch] == m_lvl[ch]) m_diff = 1'b0;
                if (m_diff) m_lvl[ch] = !m_lvl[ch];
                m_sy1[ch] = m_sy0[ch];
            end
            m_sy0[0] = set_in;
            m_sy0[1] = clr_in;

            e_s = 0; e_r = 0; e_cf = 0; e_dr = 0;
            if (m_rem > 0) begin
                if (m_ev != 2'b00) e_dr = 1;
                m_rem--;
            end else if (m_ev == 2'b01) begin
                e_s   = 1;
                m_rem = 1 + HOLD;
            end else if (m_ev == 2'b10) begin
                e_r   = 1;
                m_rem = 1 + HOLD;
            end else if (m_ev == 2'b11) begin
                e_cf = 1;
`ifdef SR_CMD_CLR_PRIORITY_EN
                e_r   = 1;
                m_rem = 1 + HOLD;
`endif
            end
            exp_q.push_back({e_s, e_r, (m_rem > 0), e_cf, e_dr});
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    logic [4:0] mon_exp;
    logic [4:0] mon_act;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {s, r, busy, conflict, dropped};
            checks++;
            if (mon_act === mon_exp) begin
                passes++;
            end else begin
                $display("FAIL outputs cycle %0d {s,r,busy,conflict,dropped} got %b expected %b",
                         cycle, mon_act, mon_exp);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic drive(input logic rs, input logic si, input logic ci, input int n);
        repeat (n) begin
            reset  = rs;
            set_in = si;
            clr_in = ci;
            @(negedge clk);
            if (rs) begin
                checks++;
                if ({s, r, busy, conflict, dropped} === 5'b00000) begin
                    passes++;
                end else begin
                    $display("FAIL reset state cycle %0d {s,r,busy,conflict,dropped} got %b expected 00000",
                             cycle, {s, r, busy, conflict, dropped});
                end
            end
        end
    endtask

    task automatic drive_expect(input logic si, input logic ci, input int n,
                                input logic want_s, input logic want_r);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            reset  = 1'b0;
            set_in = si;
            clr_in = ci;
            @(negedge clk);
            if ((want_s && s) || (want_r && r)) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            passes++;
        end else begin
            $display("FAIL wait expired cycle %0d: expected %s pulse within %0d cycles",
                     cycle, want_s ? "s" : "r", n);
        end
    endtask

    int   len;
    logic rsv;

    initial begin
        // Reset with both requests high, then release with both still held.
        drive(1, 1, 1, 3);
        drive(0, 1, 1, 20);
        drive(0, 0, 0, 20);
        // Basic latency on each channel.
        drive_expect(1, 0, 20, 1, 0);
        drive(0, 0, 0, 20);
        drive_expect(0, 1, 20, 0, 1);
        drive(0, 0, 0, 20);
        // Short glitches, then a held request.
        repeat (5) begin
            drive(0, 1, 0, 3);
            drive(0, 0, 0, 3);
        end
        drive_expect(1, 0, 10, 1, 0);
        drive(0, 0, 0, 20);
        // Clear arrives during the hold-off window, then a clean clear later.
        drive(0, 1, 0, 2);
        drive(0, 1, 1, 20);
        drive(0, 0, 0, 20);
        drive_expect(0, 1, 10, 0, 1);
        drive(0, 0, 0, 20);
        // Coincident requests.
        drive(0, 1, 1, 20);
        drive(0, 0, 0, 20);
        // Reset during hold-off, then a fresh set.
        drive(0, 1, 0, 9);
        drive(1, 1, 0, 1);
        drive(0, 0, 0, 10);
        drive(0, 1, 0, 15);
        drive(0, 0, 0, 20);
        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            len = $urandom_range(1, 12);
            rsv = ($urandom_range(0, 60) == 0);
            drive(rsv, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  rsv ? 1 : len);
        end
        drive(0, 0, 0, 30);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
